// File: rtl/overture_sequencer.sv
// Overture 8-bit CPU instruction sequencer: fetch over req/ack, decode, execute.
// Owns pc, r0-r5, the instruction register, the embedded ALU and the byte I/O ports.

module overture_alu (
  input  logic [7:0] inA,
  input  logic [7:0] inB,
  input  logic [2:0] op,
  output logic [7:0] result
);

  always_comb begin
    case (op)
      3'b000:  result = inA | inB;
      3'b001:  result = ~(inA & inB);
      3'b010:  result = ~(inA | inB);
      3'b011:  result = inA & inB;
      3'b100:  result = inA + inB;
      3'b101:  result = inA - inB;
      default: result = 8'h00;
    endcase
  end

endmodule

module overture_sequencer #(
  parameter logic [7:0] PC_RESET  = 8'h00,
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [7:0] pc,
  output logic       retire
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    EXEC     = 2'd1,
    WAIT_IN  = 2'd2,
    WAIT_OUT = 2'd3
  } state_t;

  localparam logic [1:0] CLS_IMM  = 2'b00;
  localparam logic [1:0] CLS_CALC = 2'b01;
  localparam logic [1:0] CLS_COPY = 2'b10;
  localparam logic [2:0] SEL_PORT = 3'd6;

  state_t     stateReg;
  state_t     stateNext;
  logic [7:0] pcReg;
  logic [7:0] irReg;
  logic [7:0] outDataReg;
  logic [7:0] regVal [6];

  logic [1:0] opClass;
  logic [2:0] srcSel;
  logic [2:0] dstSel;
  logic [7:0] srcVal;
  logic [7:0] aluResult;
  logic       condTaken;
  logic       fetchFire;

  logic       regWrEn;
  logic [2:0] regWrAddr;
  logic [7:0] regWrData;
  logic       pcInc;
  logic       pcLoad;
  logic       outLoad;
  logic [7:0] outLoadData;

  assign opClass   = irReg[7:6];
  assign srcSel    = irReg[5:3];
  assign dstSel    = irReg[2:0];
  assign fetchFire = imem_req & imem_ack;

  assign imem_addr = pcReg;
  assign pc        = pcReg;
  assign out_data  = outDataReg;

  // r0-r5; a write addressed to 6 or 7 matches no register and is dropped
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_reg
      logic [7:0] regQ;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regQ <= REG_RESET;
        end else if (regWrEn && regWrAddr == 3'(gi)) begin
          regQ <= regWrData;
        end
      end
      assign regVal[gi] = regQ;
    end
  endgenerate

  always_comb begin
    case (srcSel)
      3'd0:    srcVal = regVal[0];
      3'd1:    srcVal = regVal[1];
      3'd2:    srcVal = regVal[2];
      3'd3:    srcVal = regVal[3];
      3'd4:    srcVal = regVal[4];
      3'd5:    srcVal = regVal[5];
      default: srcVal = 8'h00;
    endcase
  end

  overture_alu uAlu (
    .inA    (regVal[1]),
    .inB    (regVal[2]),
    .op     (irReg[2:0]),
    .result (aluResult)
  );

  // Branch conditions treat r3 as a two's-complement value
  always_comb begin
    case (irReg[2:0])
      3'b000:  condTaken = 1'b0;
      3'b001:  condTaken = (regVal[3] == 8'h00);
      3'b010:  condTaken = regVal[3][7];
      3'b011:  condTaken = regVal[3][7] | (regVal[3] == 8'h00);
      3'b100:  condTaken = 1'b1;
      3'b101:  condTaken = (regVal[3] != 8'h00);
      3'b110:  condTaken = ~regVal[3][7];
      default: condTaken = ~regVal[3][7] & (regVal[3] != 8'h00);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= FETCH;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      FETCH: begin
        if (fetchFire) stateNext = EXEC;
      end
      EXEC: begin
        if (opClass == CLS_COPY && srcSel == SEL_PORT)      stateNext = WAIT_IN;
        else if (opClass == CLS_COPY && dstSel == SEL_PORT) stateNext = WAIT_OUT;
        else                                                stateNext = FETCH;
      end
      WAIT_IN: begin
        if (in_valid) stateNext = (dstSel == SEL_PORT) ? WAIT_OUT : FETCH;
      end
      WAIT_OUT: begin
        if (out_ready) stateNext = FETCH;
      end
      default: stateNext = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    retire      = 1'b0;
    regWrEn     = 1'b0;
    regWrAddr   = 3'd0;
    regWrData   = 8'h00;
    pcInc       = 1'b0;
    pcLoad      = 1'b0;
    outLoad     = 1'b0;
    outLoadData = 8'h00;
    case (stateReg)
      FETCH: begin
        // Gate with rst so the request drops the moment reset asserts
        imem_req = run & ~rst;
      end
      EXEC: begin
        case (opClass)
          CLS_IMM: begin
            regWrEn   = 1'b1;
            regWrAddr = 3'd0;
            regWrData = {2'b00, irReg[5:0]};
            pcInc     = 1'b1;
            retire    = 1'b1;
          end
          CLS_CALC: begin
            regWrEn   = 1'b1;
            regWrAddr = 3'd3;
            regWrData = aluResult;
            pcInc     = 1'b1;
            retire    = 1'b1;
          end
          CLS_COPY: begin
            if (srcSel == SEL_PORT) begin
              retire = 1'b0;
            end else if (dstSel == SEL_PORT) begin
              outLoad     = 1'b1;
              outLoadData = srcVal;
            end else begin
              regWrEn   = 1'b1;
              regWrAddr = dstSel;
              regWrData = srcVal;
              pcInc     = 1'b1;
              retire    = 1'b1;
            end
          end
          default: begin
            pcLoad = condTaken;
            pcInc  = ~condTaken;
            retire = 1'b1;
          end
        endcase
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (dstSel == SEL_PORT) begin
            outLoad     = 1'b1;
            outLoadData = in_data;
          end else begin
            regWrEn   = 1'b1;
            regWrAddr = dstSel;
            regWrData = in_data;
            pcInc     = 1'b1;
            retire    = 1'b1;
          end
        end
      end
      WAIT_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pcInc  = 1'b1;
          retire = 1'b1;
        end
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcReg      <= PC_RESET;
      irReg      <= 8'h00;
      outDataReg <= 8'h00;
    end else begin
      if (fetchFire) irReg <= imem_data;
      if (pcLoad) begin
        pcReg <= regVal[0];
      end else if (pcInc) begin
        pcReg <= pcReg + 8'd1;
      end
      if (outLoad) outDataReg <= outLoadData;
    end
  end

endmodule
